// File: rtl/div_arb_pkg.sv
// div_arb_pkg: shared FSM state type and divider latency helper for div_arbiter.
package div_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    function automatic int div_latency(input int a1, input int a2, input int b1);
        return a1 + a2 + b1;
    endfunction
endpackage

// File: rtl/DividerFixedPoint.sv
// DividerFixedPoint: fixed-point quotient a/b in the A1.A2 dividend format, registered once.
// A zero divisor yields out_o=0 with div_by_zero_o set; overflowing quotients wrap to AW bits.
module DividerFixedPoint #(
    parameter int A1 = 8,
    parameter int A2 = 8,
    parameter int B1 = 8,
    parameter int B2 = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [A1+A2-1:0]   a_i,
    input  logic [B1+B2-1:0]   b_i,
    output logic [A1+A2-1:0]   out_o,
    output logic               div_by_zero_o
);
    localparam int AW = A1 + A2;
    localparam int BW = B1 + B2;
    localparam int NW = AW + B2;
    logic          a_neg, b_neg;
    logic [AW-1:0] a_mag, q_mag, q_d;
    logic [BW-1:0] b_mag;
    logic [NW-1:0] num;
    assign a_neg = SIGNED && a_i[AW-1];
    assign b_neg = SIGNED && b_i[BW-1];
    assign a_mag = a_neg ? -a_i : a_i;
    assign b_mag = b_neg ? -b_i : b_i;
    // Pre-scaling by 2^B2 keeps the quotient in the dividend's fraction format.
    assign num   = NW'(a_mag) << B2;
    assign q_mag = (b_mag == '0) ? '0 : AW'(num / NW'(b_mag));
    assign q_d   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_o         <= '0;
            div_by_zero_o <= 1'b0;
        end else begin
            out_o         <= q_d;
            div_by_zero_o <= b_i == '0;
        end
    end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, highest priority at ptr_i wrapping upward.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [$clog2(NREQ)-1:0] idx_o
);
    localparam int IDW = $clog2(NREQ);
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % NREQ]) begin
                gnt_o = '0;
                gnt_o[(int'(ptr_i) + k) % NREQ] = 1'b1;
                idx_o = IDW'((int'(ptr_i) + k) % NREQ);
            end
        end
    end
endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin front end sharing one DividerFixedPoint among NREQ requesters.
// Define DIV_ARB_ZERO_BYPASS_EN to answer zero divisors directly without using the divider.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int A1 = 8,
    parameter int A2 = 8,
    parameter int B1 = 8,
    parameter int B2 = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [NREQ-1:0]          req_valid_i,
    output logic [NREQ-1:0]          req_ready_o,
    input  logic [NREQ*(A1+A2)-1:0]  req_a_i,
    input  logic [NREQ*(B1+B2)-1:0]  req_b_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [A1+A2-1:0]         resp_out_o,
    output logic                     resp_div_by_zero_o,
    output logic [$clog2(NREQ)-1:0]  resp_id_o,
    output logic                     busy_o
);
    localparam int AW  = A1 + A2;
    localparam int BW  = B1 + B2;
    localparam int IDW = $clog2(NREQ);
    localparam int LAT = div_latency(A1, A2, B1);
    localparam int CW  = $clog2(LAT + 1);
    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, gnt_idx;
    logic [NREQ-1:0] gnt;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]  op_a_q, op_a_d, out_q, out_d, a_sel, div_out;
    logic [BW-1:0]  op_b_q, op_b_d, b_sel;
    logic           dbz_q, dbz_d, div_dbz;
    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );
    DividerFixedPoint #(.A1(A1), .A2(A2), .B1(B1), .B2(B2), .SIGNED(SIGNED)) u_div (
        .clk_i         (clk_i),
        .rst_i         (~rst_n_i),
        .a_i           (op_a_q),
        .b_i           (op_b_q),
        .out_o         (div_out),
        .div_by_zero_o (div_dbz)
    );
    assign a_sel = req_a_i[gnt_idx*AW +: AW];
    assign b_sel = req_b_i[gnt_idx*BW +: BW];
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            out_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            out_q   <= out_d;
            dbz_q   <= dbz_d;
        end
    end
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        out_d   = out_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: if (|req_valid_i) begin
                op_a_d  = a_sel;
                op_b_d  = b_sel;
                id_d    = gnt_idx;
                ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                cnt_d   = CW'(LAT - 1);
                state_d = BUSY;
`ifdef DIV_ARB_ZERO_BYPASS_EN
                if (b_sel == '0) begin
                    out_d   = '0;
                    dbz_d   = 1'b1;
                    state_d = DONE;
                end
`endif
            end
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                // Only the final divider output is ever captured.
                if (cnt_q == '0) begin
                    out_d   = div_out;
                    dbz_d   = div_dbz;
                    state_d = DONE;
                end
            end
            DONE: state_d = resp_ready_i ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        req_ready_o  = (state_q == IDLE) ? gnt : '0;
        resp_valid_o = state_q == DONE;
        busy_o       = state_q != IDLE;
    end
    assign resp_out_o         = out_q;
    assign resp_div_by_zero_o = dbz_q;
    assign resp_id_o          = id_q;
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: randomized scoreboard bench for div_arbiter against an arithmetic reference model.
module tb_div_arbiter;
    localparam int NREQ = 4;
    localparam int AW = 16;
    localparam int BW = 16;
    localparam int LAT = 24;
`ifdef DIV_ARB_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    typedef struct {
        int           id;
        logic [AW-1:0] q;
        bit           dbz;
        int           acc;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [NREQ-1:0] req_valid = '0;
    logic [NREQ-1:0] req_ready;
    logic [NREQ*AW-1:0] req_a = '0;
    logic [NREQ*BW-1:0] req_b = '0;
    logic resp_valid, resp_dbz, busy;
    logic resp_ready = 1'b1;
    logic [AW-1:0] resp_out;
    logic [1:0] resp_id;

    always #5 clk = ~clk;

    div_arbiter #(.NREQ(NREQ), .A1(8), .A2(8), .B1(8), .B2(8), .SIGNED(1'b0)) dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .req_valid_i        (req_valid),
        .req_ready_o        (req_ready),
        .req_a_i            (req_a),
        .req_b_i            (req_b),
        .resp_valid_o       (resp_valid),
        .resp_ready_i       (resp_ready),
        .resp_out_o         (resp_out),
        .resp_div_by_zero_o (resp_dbz),
        .resp_id_o          (resp_id),
        .busy_o             (busy)
    );

    int errors = 0, checks = 0, cyc = 0, resp_cnt = 0, mptr = 0, mon_g, refill = 0;
    int grant_cnt[NREQ] = '{default: 0};
    int id_log[$];
    exp_t sbq[$];
    exp_t e;
    bit in_resp = 1'b0, rand_ready = 1'b0;
    logic [AW-1:0] held_out, last_out;
    logic [1:0] held_id;
    logic held_dbz, last_dbz;
    int last_id, last_lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Quotient of two 8.8 values, expressed in 8.8 and wrapped to 16 bits.
    function automatic logic [AW-1:0] ref_div(input logic [AW-1:0] a, input logic [BW-1:0] b);
        int unsigned n;
        if (b == 0) return '0;
        n = int'(a) * 256;
        return AW'(n / int'(b));
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: predicts grants, queues expected results, checks responses when presented.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_ready != '0) begin
                mon_g = -1;
                for (int k = NREQ - 1; k >= 0; k--)
                    if (req_valid[(mptr + k) % NREQ]) mon_g = (mptr + k) % NREQ;
                chk("grant", 32'(req_ready), (mon_g < 0) ? 0 : (1 << mon_g));
                if (mon_g >= 0) begin
                    e.id  = mon_g;
                    e.dbz = req_b[mon_g*BW +: BW] == 0;
                    e.q   = ref_div(req_a[mon_g*AW +: AW], req_b[mon_g*BW +: BW]);
                    e.acc = cyc;
                    e.lat = (BYP && e.dbz) ? 1 : LAT + 1;
                    sbq.push_back(e);
                    mptr = (mon_g + 1) % NREQ;
                end
            end
            if (resp_valid) begin
                chk("ready_in_done", 32'(req_ready), 0);
                if (!in_resp) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp: id %0d with nothing outstanding", resp_id);
                    end else begin
                        e = sbq.pop_front();
                        chk("resp_id", 32'(resp_id), e.id);
                        if (!(e.dbz && !BYP)) chk("resp_out", 32'(resp_out), 32'(e.q));
                        chk("resp_dbz", 32'(resp_dbz), 32'(e.dbz));
                        chk("latency", cyc - e.acc, e.lat);
                        last_lat = cyc - e.acc;
                    end
                    id_log.push_back(int'(resp_id));
                    last_out = resp_out;
                    last_id  = int'(resp_id);
                    last_dbz = resp_dbz;
                    resp_cnt++;
                    in_resp  = 1'b1;
                    held_out = resp_out;
                    held_id  = resp_id;
                    held_dbz = resp_dbz;
                end else begin
                    chk("hold_out", 32'(resp_out), 32'(held_out));
                    chk("hold_id", 32'(resp_id), 32'(held_id));
                    chk("hold_dbz", 32'(resp_dbz), 32'(held_dbz));
                end
                if (resp_ready) in_resp = 1'b0;
            end
        end
    end

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
        req_a[i*AW +: AW] = a;
        req_b[i*BW +: BW] = b;
        req_valid[i] = 1'b1;
    endtask

    function automatic logic [BW-1:0] rand_b();
        return ($urandom_range(0, 7) == 0) ? '0 : BW'($urandom);
    endfunction

    task automatic tick(input int n);
        logic [NREQ-1:0] acc;
        repeat (n) begin
            @(negedge clk);
            acc = req_ready & req_valid;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    grant_cnt[i]++;
                    if (refill == 1 || (refill == 2 && $urandom_range(0, 1) == 1))
                        set_req(i, AW'($urandom), rand_b());
                    else
                        req_valid[i] = 1'b0;
                end else if (refill == 2 && !req_valid[i] && $urandom_range(0, 7) == 0) begin
                    set_req(i, AW'($urandom), rand_b());
                end
            end
            if (rand_ready) resp_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_resps(input int target, input int budget);
        int t = 0;
        while (resp_cnt < target && t < budget) begin
            tick(1);
            t++;
        end
        if (resp_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: got %0d responses expected %0d", resp_cnt, target);
        end
    endtask

    task automatic drain();
        int t = 0;
        req_valid = '0;
        refill = 0;
        rand_ready = 1'b0;
        resp_ready = 1'b1;
        while ((busy || resp_valid || sbq.size() != 0) && t < 400) begin
            tick(1);
            t++;
        end
        if (t >= 400) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: busy %0d pending %0d expected idle", busy, sbq.size());
        end
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_valid", 32'(resp_valid), 0);
        chk("rst_out", 32'(resp_out), 0);
        chk("rst_dbz", 32'(resp_dbz), 0);
        chk("rst_id", 32'(resp_id), 0);
        chk("rst_busy", 32'(busy), 0);
        sbq.delete();
        in_resp = 1'b0;
        mptr = 0;
        req_valid = '0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [AW-1:0] a2;
        logic [BW-1:0] b1;
        int base, t;
        reset_dut();
        // Single requester, known operands.
        refill = 0;
        set_req(2, 16'h05C0, 16'h0220);
        wait_resps(1, 60);
        chk("t1_out", 32'(last_out), 32'h02B4);
        chk("t1_id", last_id, 2);
        chk("t1_lat", last_lat, 25);
        chk("t1_grants", grant_cnt[2], 1);
        drain();
        // All requesters continuously valid: rotation from requester 0.
        reset_dut();
        id_log.delete();
        refill = 1;
        for (int i = 0; i < NREQ; i++) set_req(i, AW'($urandom), rand_b());
        wait_resps(resp_cnt + 5, 200);
        for (int k = 0; k < 5; k++) chk("t2_seq", (k < id_log.size()) ? id_log[k] : -1, k % NREQ);
        drain();
        // Consumer stalls in DONE.
        refill = 1;
        resp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, AW'($urandom), BW'($urandom_range(1, 65535)));
        wait_resps(resp_cnt + 1, 60);
        tick(10);
        chk("t3_valid_held", 32'(resp_valid), 1);
        resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t3_next_grant", 32'(req_ready != '0), 1);
        @(posedge clk);
        #1;
        drain();
        // Zero divisor.
        refill = 0;
        set_req(1, AW'($urandom), '0);
        base = resp_cnt;
        wait_resps(base + 1, 60);
        chk("t4_dbz", 32'(last_dbz), 1);
        chk("t4_lat", last_lat, BYP ? 1 : LAT + 1);
        drain();
        // Asynchronous reset while an op is in flight.
        refill = 0;
        base = grant_cnt[2];
        set_req(2, AW'($urandom), BW'($urandom_range(1, 65535)));
        t = 0;
        while (grant_cnt[2] == base && t < 20) begin
            tick(1);
            t++;
        end
        tick(10);
        chk("t5_busy_before", 32'(busy), 1);
        reset_dut();
        id_log.delete();
        refill = 1;
        for (int i = 0; i < NREQ; i++) set_req(i, AW'($urandom), rand_b());
        wait_resps(resp_cnt + 2, 120);
        chk("t5_first_id", (id_log.size() > 0) ? id_log[0] : -1, 0);
        drain();
        // Waiting requester updates its operands before being granted.
        reset_dut();
        refill = 0;
        a2 = AW'($urandom);
        b1 = BW'($urandom_range(1, 65535));
        set_req(0, AW'($urandom), BW'($urandom_range(1, 65535)));
        set_req(3, AW'($urandom), b1);
        base = resp_cnt;
        tick(1);
        req_a[3*AW +: AW] = a2;
        wait_resps(base + 2, 120);
        chk("t6_id", last_id, 3);
        chk("t6_out", 32'(last_out), 32'(ref_div(a2, b1)));
        drain();
        // Random traffic with a randomly stalling consumer.
        refill = 2;
        rand_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) if ($urandom_range(0, 1) == 1) set_req(i, AW'($urandom), rand_b());
        set_req(0, AW'($urandom), rand_b());
        wait_resps(resp_cnt + 25, 4000);
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
